// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the broadcast AXI4-Lite control write path:
// response codes, join FSM states and the default leg count.
package axi_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEFAULT_NUM_SLR = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    RESP    = 1'b1
  } join_state_t;

endpackage

// File: rtl/axi_fork_tracker.sv
// Forks one valid/ready handshake to NUM_SLR legs; each leg is offered the
// beat until it accepts, and the upstream side completes once every leg has.
module axi_fork_tracker
  import axi_ctrl_pkg::*;
#(
  parameter int NUM_SLR = DEFAULT_NUM_SLR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_SLR-1:0] out_valid,
  input  logic [NUM_SLR-1:0] out_ready,
  input  logic               enable
);

  logic [NUM_SLR-1:0] done;

  assign out_valid = {NUM_SLR{in_valid & enable}} & ~done;
  assign in_ready  = enable & (&(done | out_ready));

  // A completed upstream handshake restarts tracking, so no leg sees a duplicate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      done <= '0;
    else if (in_valid && in_ready)
      done <= '0;
    else
      done <= done | (out_valid & out_ready);
  end

endmodule

// File: rtl/axi_ctrl_write_fork_join.sv
// Broadcast control write: forks AW/W to every SLR leg, joins the per-leg B
// responses into one merged upstream response, and limits outstanding writes.
//
// state   | meaning
// COLLECT | gathering B responses from the legs
// RESP    | merged response presented upstream, waiting for BREADY
module axi_ctrl_write_fork_join
  import axi_ctrl_pkg::*;
#(
  parameter int NUM_SLR                    = DEFAULT_NUM_SLR,
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 9,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING            = 4
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst,
  input  logic                                    s_axi_control_AWVALID,
  output logic                                    s_axi_control_AWREADY,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
  input  logic                                    s_axi_control_WVALID,
  output logic                                    s_axi_control_WREADY,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_WDATA,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
  output logic                                    s_axi_control_BVALID,
  input  logic                                    s_axi_control_BREADY,
  output logic [1:0]                              s_axi_control_BRESP,
  output logic [NUM_SLR-1:0]                      m_axi_control_AWVALID,
  input  logic [NUM_SLR-1:0]                      m_axi_control_AWREADY,
  output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   m_axi_control_AWADDR,
  output logic [NUM_SLR-1:0]                      m_axi_control_WVALID,
  input  logic [NUM_SLR-1:0]                      m_axi_control_WREADY,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   m_axi_control_WDATA,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] m_axi_control_WSTRB,
  input  logic [NUM_SLR-1:0]                      m_axi_control_BVALID,
  output logic [NUM_SLR-1:0]                      m_axi_control_BREADY,
  input  logic [2*NUM_SLR-1:0]                    m_axi_control_BRESP,
  output logic                                    err_unexpected_b
);

  logic [3:0]           outstanding;
  logic                 credit_ok;
  logic                 aw_hs;
  logic                 b_hs;
  join_state_t          state, state_n;
  logic [NUM_SLR-1:0]   b_got, b_got_n, leg_b_hs;
  logic [2*NUM_SLR-1:0] b_resp, b_resp_n;
  logic                 s_bvalid_n;
  logic [1:0]           s_bresp_n;

  function automatic logic [1:0] merge_resp(input logic [2*NUM_SLR-1:0] r);
    logic any_dec, any_slv, all_exo;
    any_dec = 1'b0;
    any_slv = 1'b0;
    all_exo = 1'b1;
    for (int i = 0; i < NUM_SLR; i++) begin
      any_dec = any_dec | (r[2*i +: 2] == RESP_DECERR);
      any_slv = any_slv | (r[2*i +: 2] == RESP_SLVERR);
      all_exo = all_exo & (r[2*i +: 2] == RESP_EXOKAY);
    end
    if (any_dec)      return RESP_DECERR;
    else if (any_slv) return RESP_SLVERR;
    else if (all_exo) return RESP_EXOKAY;
    else              return RESP_OKAY;
  endfunction

  assign credit_ok            = outstanding < 4'(MAX_OUTSTANDING);
  assign aw_hs                = s_axi_control_AWVALID & s_axi_control_AWREADY;
  assign b_hs                 = s_axi_control_BVALID & s_axi_control_BREADY;
  assign m_axi_control_AWADDR = s_axi_control_AWADDR;
  assign m_axi_control_WDATA  = s_axi_control_WDATA;
  assign m_axi_control_WSTRB  = s_axi_control_WSTRB;
  assign m_axi_control_BREADY = ~b_got;
  assign leg_b_hs             = m_axi_control_BVALID & ~b_got;

  axi_fork_tracker #(.NUM_SLR(NUM_SLR)) u_aw_fork (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_valid  (s_axi_control_AWVALID),
    .in_ready  (s_axi_control_AWREADY),
    .out_valid (m_axi_control_AWVALID),
    .out_ready (m_axi_control_AWREADY),
    .enable    (credit_ok)
  );

  axi_fork_tracker #(.NUM_SLR(NUM_SLR)) u_w_fork (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_valid  (s_axi_control_WVALID),
    .in_ready  (s_axi_control_WREADY),
    .out_valid (m_axi_control_WVALID),
    .out_ready (m_axi_control_WREADY),
    .enable    (1'b1)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      outstanding <= '0;
    else if (aw_hs && !b_hs && outstanding < 4'(MAX_OUTSTANDING))
      outstanding <= outstanding + 4'd1;
    else if (b_hs && !aw_hs && outstanding != 4'd0)
      outstanding <= outstanding - 4'd1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      err_unexpected_b <= 1'b0;
    else if (|m_axi_control_BVALID && outstanding == 4'd0)
      err_unexpected_b <= 1'b1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state                <= COLLECT;
      b_got                <= '0;
      b_resp               <= '0;
      s_axi_control_BVALID <= 1'b0;
      s_axi_control_BRESP  <= RESP_OKAY;
    end else begin
      state                <= state_n;
      b_got                <= b_got_n;
      b_resp               <= b_resp_n;
      s_axi_control_BVALID <= s_bvalid_n;
      s_axi_control_BRESP  <= s_bresp_n;
    end
  end

  // Merge sees this cycle's captures, so the response is registered one cycle after the last leg.
  always_comb begin
    state_n    = state;
    b_got_n    = b_got | leg_b_hs;
    b_resp_n   = b_resp;
    s_bvalid_n = s_axi_control_BVALID;
    s_bresp_n  = s_axi_control_BRESP;
    for (int i = 0; i < NUM_SLR; i++)
      if (leg_b_hs[i]) b_resp_n[2*i +: 2] = m_axi_control_BRESP[2*i +: 2];
    case (state)
      COLLECT: begin
        if (&b_got_n) begin
          state_n    = RESP;
          s_bvalid_n = 1'b1;
          s_bresp_n  = merge_resp(b_resp_n);
        end
      end
      RESP: begin
        if (b_hs) begin
          state_n    = COLLECT;
          b_got_n    = '0;
          s_bvalid_n = 1'b0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_axi_ctrl_write_fork_join.sv
// Directed bench for axi_ctrl_write_fork_join; a monitor checks merged B
// responses against a queue of hand-computed expectations.
module tb_axi_ctrl_write_fork_join;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 32;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic            s_axi_control_AWVALID;
  logic            s_axi_control_AWREADY;
  logic [AW-1:0]   s_axi_control_AWADDR;
  logic            s_axi_control_WVALID;
  logic            s_axi_control_WREADY;
  logic [DW-1:0]   s_axi_control_WDATA;
  logic [DW/8-1:0] s_axi_control_WSTRB;
  logic            s_axi_control_BVALID;
  logic            s_axi_control_BREADY;
  logic [1:0]      s_axi_control_BRESP;
  logic [N-1:0]    m_axi_control_AWVALID;
  logic [N-1:0]    m_axi_control_AWREADY;
  logic [AW-1:0]   m_axi_control_AWADDR;
  logic [N-1:0]    m_axi_control_WVALID;
  logic [N-1:0]    m_axi_control_WREADY;
  logic [DW-1:0]   m_axi_control_WDATA;
  logic [DW/8-1:0] m_axi_control_WSTRB;
  logic [N-1:0]    m_axi_control_BVALID;
  logic [N-1:0]    m_axi_control_BREADY;
  logic [2*N-1:0]  m_axi_control_BRESP;
  logic            err_unexpected_b;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  int aw_cnt[N] = '{default: 0};
  int w_cnt[N]  = '{default: 0};

  axi_ctrl_write_fork_join #(
    .NUM_SLR(N), .C_S_AXI_CONTROL_ADDR_WIDTH(AW),
    .C_S_AXI_CONTROL_DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axi_control_AWVALID(s_axi_control_AWVALID), .s_axi_control_AWREADY(s_axi_control_AWREADY),
    .s_axi_control_AWADDR(s_axi_control_AWADDR),
    .s_axi_control_WVALID(s_axi_control_WVALID), .s_axi_control_WREADY(s_axi_control_WREADY),
    .s_axi_control_WDATA(s_axi_control_WDATA), .s_axi_control_WSTRB(s_axi_control_WSTRB),
    .s_axi_control_BVALID(s_axi_control_BVALID), .s_axi_control_BREADY(s_axi_control_BREADY),
    .s_axi_control_BRESP(s_axi_control_BRESP),
    .m_axi_control_AWVALID(m_axi_control_AWVALID), .m_axi_control_AWREADY(m_axi_control_AWREADY),
    .m_axi_control_AWADDR(m_axi_control_AWADDR),
    .m_axi_control_WVALID(m_axi_control_WVALID), .m_axi_control_WREADY(m_axi_control_WREADY),
    .m_axi_control_WDATA(m_axi_control_WDATA), .m_axi_control_WSTRB(m_axi_control_WSTRB),
    .m_axi_control_BVALID(m_axi_control_BVALID), .m_axi_control_BREADY(m_axi_control_BREADY),
    .m_axi_control_BRESP(m_axi_control_BRESP),
    .err_unexpected_b(err_unexpected_b)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts leg beats and scores every upstream B handshake.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < N; i++) begin
        if (m_axi_control_AWVALID[i] && m_axi_control_AWREADY[i]) aw_cnt[i]++;
        if (m_axi_control_WVALID[i] && m_axi_control_WREADY[i]) w_cnt[i]++;
      end
      if (s_axi_control_BVALID && s_axi_control_BREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected actual=%0h required=none", s_axi_control_BRESP);
        end else begin
          check("b_resp", 32'(s_axi_control_BRESP), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  // All legs answer in one cycle; optional upstream BREADY stall.
  task automatic b_round(input logic [2*N-1:0] r, input logic [1:0] e, input int stall);
    exp_q.push_back(e);
    next_cycle();
    m_axi_control_BVALID = '1;
    m_axi_control_BRESP  = r;
    s_axi_control_BREADY = (stall == 0);
    next_cycle();
    m_axi_control_BVALID = '0;
    for (int k = 0; k < stall; k++) begin
      @(negedge ap_clk);
      check("bvalid_hold", 32'(s_axi_control_BVALID), 32'd1);
      check("bresp_hold", 32'(s_axi_control_BRESP), 32'(e));
      next_cycle();
    end
    s_axi_control_BREADY = 1'b1;
    @(negedge ap_clk);
    check("bvalid_round", 32'(s_axi_control_BVALID), 32'd1);
    next_cycle();
  endtask

  initial begin
    ap_rst = 1'b1;
    s_axi_control_AWVALID = 0; s_axi_control_AWADDR = '0;
    s_axi_control_WVALID = 0;  s_axi_control_WDATA = '0; s_axi_control_WSTRB = '0;
    s_axi_control_BREADY = 1;
    m_axi_control_AWREADY = '0; m_axi_control_WREADY = '0;
    m_axi_control_BVALID = '0;  m_axi_control_BRESP = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_bvalid", 32'(s_axi_control_BVALID), 32'd0);
    check("rst_bresp", 32'(s_axi_control_BRESP), 32'd0);
    check("rst_err", 32'(err_unexpected_b), 32'd0);
    check("rst_bready", 32'(m_axi_control_BREADY), 32'hF);
    check("rst_awvalid", 32'(m_axi_control_AWVALID), 32'h0);
    check("rst_awready", 32'(s_axi_control_AWREADY), 32'd0);
    check("rst_outstanding", 32'(dut.outstanding), 32'd0);
    next_cycle();
    ap_rst = 1'b0;

    // Single write, all legs ready
    m_axi_control_AWREADY = '1; m_axi_control_WREADY = '1;
    s_axi_control_AWVALID = 1; s_axi_control_AWADDR = 9'h010;
    s_axi_control_WVALID = 1;  s_axi_control_WDATA = 32'hDEADBEEF; s_axi_control_WSTRB = 4'hF;
    @(negedge ap_clk);
    check("t1_awready", 32'(s_axi_control_AWREADY), 32'd1);
    check("t1_wready", 32'(s_axi_control_WREADY), 32'd1);
    check("t1_m_awvalid", 32'(m_axi_control_AWVALID), 32'hF);
    check("t1_m_wvalid", 32'(m_axi_control_WVALID), 32'hF);
    check("t1_m_awaddr", 32'(m_axi_control_AWADDR), 32'h010);
    check("t1_m_wdata", m_axi_control_WDATA, 32'hDEADBEEF);
    check("t1_m_wstrb", 32'(m_axi_control_WSTRB), 32'hF);
    next_cycle();
    s_axi_control_AWVALID = 0; s_axi_control_WVALID = 0;
    @(negedge ap_clk);
    check("t1_outstanding", 32'(dut.outstanding), 32'd1);
    for (int i = 0; i < N; i++) begin
      check("t1_aw_cnt", 32'(aw_cnt[i]), 32'd1);
      check("t1_w_cnt", 32'(w_cnt[i]), 32'd1);
    end

    // Staggered B: OKAY, OKAY, SLVERR, OKAY
    exp_q.push_back(2'b10);
    m_axi_control_BRESP = 8'h20;
    for (int i = 0; i < N; i++) begin
      next_cycle();
      m_axi_control_BVALID = 4'(1 << i);
      @(negedge ap_clk);
      check("t3_bvalid_early", 32'(s_axi_control_BVALID), 32'd0);
    end
    next_cycle();
    m_axi_control_BVALID = '0;
    @(negedge ap_clk);
    check("t3_bvalid", 32'(s_axi_control_BVALID), 32'd1);
    check("t3_bready_all_got", 32'(m_axi_control_BREADY), 32'h0);
    next_cycle();
    @(negedge ap_clk);
    check("t3_bvalid_clear", 32'(s_axi_control_BVALID), 32'd0);
    check("t3_bready_rearm", 32'(m_axi_control_BREADY), 32'hF);
    check("t3_outstanding", 32'(dut.outstanding), 32'd0);

    // Leg 2 AWREADY low for 3 cycles
    next_cycle();
    s_axi_control_AWVALID = 1; s_axi_control_AWADDR = 9'h020;
    m_axi_control_AWREADY = 4'b1011;
    @(negedge ap_clk);
    check("t2_awready_c0", 32'(s_axi_control_AWREADY), 32'd0);
    check("t2_m_awvalid_c0", 32'(m_axi_control_AWVALID), 32'hF);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge ap_clk);
      check("t2_m_awvalid_wait", 32'(m_axi_control_AWVALID), 32'h4);
      check("t2_awready_wait", 32'(s_axi_control_AWREADY), 32'd0);
    end
    next_cycle();
    m_axi_control_AWREADY = '1;
    @(negedge ap_clk);
    check("t2_awready_rise", 32'(s_axi_control_AWREADY), 32'd1);
    check("t2_m_awvalid_last", 32'(m_axi_control_AWVALID), 32'h4);
    next_cycle();
    s_axi_control_AWVALID = 0;
    s_axi_control_WVALID = 1; s_axi_control_WDATA = 32'h12345678;
    next_cycle();
    s_axi_control_WVALID = 0;
    @(negedge ap_clk);
    for (int i = 0; i < N; i++) begin
      check("t2_aw_cnt", 32'(aw_cnt[i]), 32'd2);
      check("t2_w_cnt", 32'(w_cnt[i]), 32'd2);
    end
    check("t2_outstanding", 32'(dut.outstanding), 32'd1);

    // Fill credits to 4, fifth write blocked until one B round
    next_cycle();
    s_axi_control_AWVALID = 1; s_axi_control_AWADDR = 9'h040;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check("t4_awready_fill", 32'(s_axi_control_AWREADY), 32'd1);
      next_cycle();
    end
    @(negedge ap_clk);
    check("t4_awready_full", 32'(s_axi_control_AWREADY), 32'd0);
    check("t4_m_awvalid_full", 32'(m_axi_control_AWVALID), 32'h0);
    check("t4_outstanding_full", 32'(dut.outstanding), 32'd4);
    exp_q.push_back(2'b01);
    next_cycle();
    m_axi_control_BVALID = '1; m_axi_control_BRESP = 8'h55;
    @(negedge ap_clk);
    check("t4_awready_hold1", 32'(s_axi_control_AWREADY), 32'd0);
    next_cycle();
    m_axi_control_BVALID = '0;
    @(negedge ap_clk);
    check("t4_bvalid", 32'(s_axi_control_BVALID), 32'd1);
    check("t4_awready_hold2", 32'(s_axi_control_AWREADY), 32'd0);
    next_cycle();
    @(negedge ap_clk);
    check("t4_outstanding_rel", 32'(dut.outstanding), 32'd3);
    check("t4_awready_rel", 32'(s_axi_control_AWREADY), 32'd1);
    check("t4_m_awvalid_rel", 32'(m_axi_control_AWVALID), 32'hF);
    next_cycle();
    s_axi_control_AWVALID = 0;
    @(negedge ap_clk);
    check("t4_outstanding_refill", 32'(dut.outstanding), 32'd4);

    // Merge variants; DECERR round stalls BREADY
    b_round(8'h44, 2'b00, 0);
    b_round(8'h8C, 2'b11, 2);
    @(negedge ap_clk);
    check("t5_outstanding_pre", 32'(dut.outstanding), 32'd2);

    // Simultaneous upstream AW and B handshakes
    exp_q.push_back(2'b00);
    next_cycle();
    m_axi_control_BVALID = '1; m_axi_control_BRESP = 8'h00;
    next_cycle();
    m_axi_control_BVALID = '0;
    s_axi_control_AWVALID = 1; s_axi_control_AWADDR = 9'h030;
    @(negedge ap_clk);
    check("t5_bvalid", 32'(s_axi_control_BVALID), 32'd1);
    check("t5_awready", 32'(s_axi_control_AWREADY), 32'd1);
    next_cycle();
    s_axi_control_AWVALID = 0;
    @(negedge ap_clk);
    check("t5_outstanding", 32'(dut.outstanding), 32'd2);

    // Drain, then a stray B beat with nothing outstanding
    b_round(8'h00, 2'b00, 0);
    b_round(8'h00, 2'b00, 0);
    @(negedge ap_clk);
    check("t6_outstanding", 32'(dut.outstanding), 32'd0);
    check("t6_err_before", 32'(err_unexpected_b), 32'd0);
    next_cycle();
    m_axi_control_BVALID = 4'b0010;
    next_cycle();
    m_axi_control_BVALID = '0;
    @(negedge ap_clk);
    check("t6_err_set", 32'(err_unexpected_b), 32'd1);
    check("t6_bready_stray", 32'(m_axi_control_BREADY), 32'hD);
    repeat (3) next_cycle();
    @(negedge ap_clk);
    check("t6_err_sticky", 32'(err_unexpected_b), 32'd1);

    // Reset in the middle of a partially forked write
    next_cycle();
    s_axi_control_AWVALID = 1; s_axi_control_AWADDR = 9'h050;
    m_axi_control_AWREADY = 4'b0001;
    next_cycle();
    @(negedge ap_clk);
    check("t7_m_awvalid_partial", 32'(m_axi_control_AWVALID), 32'hE);
    #2 ap_rst = 1'b1;
    #1;
    check("t7_err_rst", 32'(err_unexpected_b), 32'd0);
    check("t7_m_awvalid_rst", 32'(m_axi_control_AWVALID), 32'hF);
    check("t7_bready_rst", 32'(m_axi_control_BREADY), 32'hF);
    check("t7_bvalid_rst", 32'(s_axi_control_BVALID), 32'd0);
    check("t7_outstanding_rst", 32'(dut.outstanding), 32'd0);
    s_axi_control_AWVALID = 0;
    repeat (2) @(posedge ap_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
